// File: rtl/dmem_mmio.sv
// Data memory with a small memory-mapped channel register window.
// Each access takes a fixed number of cycles (WAIT) and ends with a one-cycle ready pulse.
module dmem_mmio #(
  parameter int          DEPTH     = 1024,
  parameter int          NCH       = 2,
  parameter logic [31:0] MMIO_BASE = 32'h00001000,
  parameter int          WAIT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       adr,
  input  logic [31:0]       writedata,
  output logic              ready,
  output logic [31:0]       memdata,
  output logic              fault,
  output logic [NCH*32-1:0] chan
);

  // state | meaning
  // IDLE  | waiting for req; request fields captured on accept
  // BUSY  | counting down the WAIT cycles
  // DONE  | ready=1 for one cycle; stores commit on the edge leaving it
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WAIT_M1 = (WAIT > 0) ? WAIT - 1 : 0;

  logic [1:0]  st;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] md_hold;
  logic        flt_hold;
  logic [31:0] chan_r [NCH];
  logic [31:0] mem    [DEPTH];

  logic [32:0]   off;
  logic          mm_hit;
  logic          ram_hit;
  logic [CW-1:0] cidx;
  logic [AW-1:0] widx;
  logic          flt_c;
  logic [31:0]   src;
  logic [31:0]   lane;
  logic [31:0]   ld;
  logic [31:0]   mask;
  logic [31:0]   wval;
  logic [31:0]   wword;
  logic [31:0]   md_c;
  logic          wr_chan;
  logic          wr_ram;

  always_comb begin
    off     = {1'b0, a_q} - {1'b0, MMIO_BASE};
    mm_hit  = !off[32] && (off < 33'(4 * NCH));
    ram_hit = a_q[31:2] < 30'(DEPTH);
    cidx    = off[2 +: CW];
    widx    = a_q[2 +: AW];
    flt_c   = (size_q == 2'b11) ||
              (size_q == 2'b01 && a_q[0]) ||
              (size_q == 2'b10 && a_q[1:0] != 2'b00) ||
              (mm_hit && size_q != 2'b10) ||
              (!mm_hit && !ram_hit);
    src     = mm_hit ? chan_r[cidx] : mem[widx];
    ld      = src;
    mask    = 32'hFFFF_FFFF;
    wval    = wd_q;
    lane    = src;
    case (size_q)
      2'b00: begin
        lane = src >> {a_q[1:0], 3'b000};
        ld   = uns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        mask = 32'h0000_00FF << {a_q[1:0], 3'b000};
        wval = {4{wd_q[7:0]}};
      end
      2'b01: begin
        lane = src >> {a_q[1], 4'b0000};
        ld   = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        mask = 32'h0000_FFFF << {a_q[1], 4'b0000};
        wval = {2{wd_q[15:0]}};
      end
      default: ;
    endcase
    wword   = (src & ~mask) | (wval & mask);
    md_c    = (we_q || flt_c) ? 32'h0 : ld;
    wr_chan = we_q && !flt_c && mm_hit;
    wr_ram  = we_q && !flt_c && !mm_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      cnt      <= 4'd0;
      a_q      <= 32'h0;
      wd_q     <= 32'h0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      md_hold  <= 32'h0;
      flt_hold <= 1'b0;
      for (int k = 0; k < NCH; k++) chan_r[k] <= 32'h0;
    end else begin
      case (st)
        IDLE: if (req) begin
          a_q    <= adr;
          wd_q   <= writedata;
          we_q   <= we;
          size_q <= size;
          uns_q  <= uns;
          cnt    <= WAIT_M1[3:0];
          st     <= (WAIT > 0) ? BUSY : DONE;
        end
        BUSY: begin
          if (cnt == 4'd0) st <= DONE;
          else cnt <= cnt - 4'd1;
        end
        DONE: begin
          st       <= IDLE;
          md_hold  <= md_c;
          flt_hold <= flt_c;
          if (wr_chan) chan_r[cidx] <= wword;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (st == DONE && wr_ram) mem[widx] <= wword;
  end

  assign ready   = (st == DONE);
  assign memdata = (st == DONE) ? md_c : md_hold;
  assign fault   = (st == DONE) ? flt_c : flt_hold;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[32*k +: 32] = chan_r[k];
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio against an arithmetic reference model,
// plus directed word/byte/fault/MMIO/reset cases and a WAIT=0 back-to-back instance.
module tb_dmem_mmio;
  localparam int          DEPTH = 256;
  localparam int          NCH   = 2;
  localparam int          W     = 1;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  logic req, we, uns, ready, fault;
  logic [1:0] size;
  logic [31:0] adr, wd, memdata;
  logic [NCH*32-1:0] chan;

  logic req_z, we_z, uns_z, ready_z, fault_z;
  logic [1:0] size_z;
  logic [31:0] adr_z, wd_z, memdata_z;
  logic [NCH*32-1:0] chan_z;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_mem  [DEPTH];
  logic [31:0] m_chan [NCH];
  logic [31:0] b2b_dat [4];

  always #5 clk = ~clk;

  dmem_mmio #(.DEPTH(DEPTH), .NCH(NCH), .MMIO_BASE(BASE), .WAIT(W)) u_dut (
    .clk(clk), .reset(rst), .req(req), .we(we), .size(size), .uns(uns),
    .adr(adr), .writedata(wd), .ready(ready), .memdata(memdata),
    .fault(fault), .chan(chan)
  );

  dmem_mmio #(.DEPTH(DEPTH), .NCH(NCH), .MMIO_BASE(BASE), .WAIT(0)) u_dut_z (
    .clk(clk), .reset(rst), .req(req_z), .we(we_z), .size(size_z), .uns(uns_z),
    .adr(adr_z), .writedata(wd_z), .ready(ready_z), .memdata(memdata_z),
    .fault(fault_z), .chan(chan_z)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: classify the address, then read/modify lanes with plain arithmetic.
  task automatic ref_acc(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic flt);
    longint unsigned la;
    bit mm, rm;
    int lanes, bytes;
    logic [31:0] word, mask, v;
    la = a;
    mm = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * NCH);
    rm = (la / 4) < DEPTH;
    flt = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          (mm && sz != 2'd2) || (!mm && !rm);
    rd = 32'h0;
    if (!flt) begin
      word  = mm ? m_chan[(a - BASE) / 4] : m_mem[a / 4];
      lanes = a % 4;
      bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mask  = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
      if (w) begin
        word = (word & ~(mask << (8 * lanes))) | ((d & mask) << (8 * lanes));
        if (mm) m_chan[(a - BASE) / 4] = word;
        else m_mem[a / 4] = word;
      end else begin
        v = (word >> (8 * lanes)) & mask;
        if (!u && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
        rd = v;
      end
    end
  endtask

  task automatic dut_acc(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic flt, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; adr = a; wd = d;
    @(posedge clk); #1;
    // garbage on every input while the access is in flight
    req = 1'($urandom_range(0, 1)); we = 1'($urandom); size = 2'($urandom);
    uns = 1'($urandom); adr = $urandom; wd = $urandom;
    lat = 0;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    rd  = memdata;
    flt = fault;
  endtask

  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic flt);
    logic [31:0] e_rd;
    logic        e_flt;
    int          lat;
    ref_acc(w, sz, u, a, d, e_rd, e_flt);
    dut_acc(w, sz, u, a, d, rd, flt, lat);
    chk({tag, " latency"}, 64'(lat), 64'(W));
    chk({tag, " memdata"}, rd, e_rd);
    chk({tag, " fault"}, flt, e_flt);
    @(posedge clk); #1;
    chk({tag, " ready pulse"}, ready, 1'b0);
    chk({tag, " memdata hold"}, memdata, e_rd);
    chk({tag, " fault hold"}, fault, e_flt);
    chk({tag, " chan"}, chan, {m_chan[1], m_chan[0]});
  endtask

  task automatic b2b(input string tag, input logic w, input logic [31:0] base);
    int k, pulses;
    @(negedge clk);
    req_z = 1'b1; we_z = w; size_z = 2'd2; uns_z = 1'b0; adr_z = base; wd_z = b2b_dat[0];
    k = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk({tag, " ready pattern"}, ready_z, (i % 2 == 0));
      if (ready_z) begin
        pulses++;
        if (!w && k < 4) chk({tag, " load data"}, memdata_z, b2b_dat[k]);
        chk({tag, " fault"}, fault_z, 1'b0);
        k++;
        if (k < 4) begin
          adr_z = base + 32'(4 * k);
          wd_z  = b2b_dat[k];
        end
      end
      if (i == 7) req_z = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, " idle after"}, ready_z, 1'b0);
    chk({tag, " pulse count"}, 64'(pulses), 64'd4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, prior, a;
    logic        flt;
    logic [1:0]  sz;
    rst = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; adr = 32'h0; wd = 32'h0;
    req_z = 1'b0; we_z = 1'b0; size_z = 2'd0; uns_z = 1'b0; adr_z = 32'h0; wd_z = 32'h0;
    for (int k = 0; k < NCH; k++) m_chan[k] = 32'h0;
    #23;
    chk("reset ready", ready, 1'b0);
    chk("reset memdata", memdata, 32'h0);
    chk("reset fault", fault, 1'b0);
    chk("reset chan", chan, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) run("init", 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, rd, flt);

    run("word store", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt);
    run("word load", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, flt);
    chk("word load value", rd, 32'hDEADBEEF);
    chk("word load ok", flt, 1'b0);

    run("byte store", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0080, rd, flt);
    run("byte load s", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, flt);
    chk("byte load signed", rd, 32'hFFFF_FF80);
    run("byte load u", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd, flt);
    chk("byte load unsigned", rd, 32'h0000_0080);
    run("word after byte", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, flt);
    chk("word after byte value", rd, 32'hDEAD80EF);

    run("half misaligned", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, rd, flt);
    chk("half misaligned fault", flt, 1'b1);
    run("word misaligned", 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, rd, flt);
    chk("word misaligned fault", flt, 1'b1);
    run("out of range", 1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h5555_AAAA, rd, flt);
    chk("out of range fault", flt, 1'b1);
    chk("out of range memdata", rd, 32'h0);

    run("mmio st0", 1'b1, 2'd2, 1'b0, 32'h1000, 32'h0000_1234, rd, flt);
    run("mmio st1", 1'b1, 2'd2, 1'b0, 32'h1004, 32'h0000_4321, rd, flt);
    chk("mmio chan value", chan, 64'h0000_4321_0000_1234);
    run("mmio ld0", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, flt);
    chk("mmio ld0 value", rd, 32'h0000_1234);
    run("mmio ld1", 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, rd, flt);
    chk("mmio ld1 value", rd, 32'h0000_4321);

    prior = m_mem[8];
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; adr = 32'h20; wd = ~prior;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset ready", ready, 1'b0);
    chk("midreset memdata", memdata, 32'h0);
    chk("midreset fault", fault, 1'b0);
    chk("midreset chan", chan, 64'h0);
    for (int k = 0; k < NCH; k++) m_chan[k] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midreset no ready", ready, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    run("after reset load", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, flt);
    chk("after reset prior", rd, prior);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 4 * DEPTH - 1);
        1: a = 32'(4 * DEPTH - 4) + $urandom_range(0, 7);
        2: a = BASE - 32'd4 + $urandom_range(0, 4 * NCH + 7);
        3: a = $urandom;
        default: a = $urandom_range(0, 63);
      endcase
      sz = 2'($urandom_range(0, 3));
      run("random", 1'($urandom), sz, 1'($urandom), a, $urandom, rd, flt);
    end

    for (int k = 0; k < 4; k++) b2b_dat[k] = $urandom;
    b2b("b2b store", 1'b1, 32'h40);
    b2b("b2b load", 1'b0, 32'h40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
